fil_sequencer: RTL and testbench
================================

Name: fil_sequencer

Overview:
- Fault-injection-list sequencer. It is the responder on the controller's FIL_INC / FIL_END interface, and replaces the fixed-delay FIL_END in the top level.
- On each FIL_INC request it selects the next fault, lets the CUT settle, and acknowledges.
- After the last fault is served and one further request arrives, it raises FIL_END.
- Sits beside the mid section. FAULT_ID and FAULT_VALID drive the fault-injection muxes. The controller's error counter is read once FIL_END is high.

Parameters:
- TOT_FAULT_BITS, 10: width of FAULT_ID and INJ_COUNT. Requires ERR_TOTAL < 2**TOT_FAULT_BITS.
- ERR_TOTAL, 528: number of faults in the list, indexed 0..ERR_TOTAL-1.
- SETTLE_CYCLES, 2: cycles the fault is held before FIL_ACK. Valid range 0..255.
- TIMEOUT, 1024: HOLD-state watchdog limit in cycles. Used only with FIL_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- FIL_INC, input, 1: level request from the controller. Only its rising edge is acted on.
- FAULT_ID, output, TOT_FAULT_BITS: index of the currently injected fault.
- FAULT_POL, output, 1: stuck-at value, equal to FAULT_ID[0] (even = SA0, odd = SA1).
- FAULT_VALID, output, 1: a fault is being injected. When 0, the CUT runs fault-free (golden).
- FIL_ACK, output, 1: one-cycle pulse meaning the fault has settled.
- FIL_END, output, 1: sticky flag, all faults done.
- INJ_COUNT, output, TOT_FAULT_BITS: number of faults injected so far.
- TIMEOUT_FLAG, output, 1: sticky watchdog flag. Tied to 0 when the macro is absent.

Behaviour:
- Reset and clocking:
  - One clock domain. rst is synchronous and active-high and overrides all other inputs.
  - Reset values: state = GOLDEN; FAULT_ID = 0, FAULT_POL = 0, FAULT_VALID = 0, FIL_ACK = 0, FIL_END = 0, INJ_COUNT = 0, TIMEOUT_FLAG = 0.
  - The edge-detect register (inc_d) resets to 0.
- Edge detect: inc_edge = FIL_INC & ~inc_d, where inc_d is registered FIL_INC. A level held high gives exactly one edge.
- States: GOLDEN, SETTLE, HOLD, DONE.
- GOLDEN: FAULT_VALID = 0 while the controller runs the golden pass. On inc_edge:
  - FAULT_ID <= 0, FAULT_VALID <= 1, INJ_COUNT <= 1.
  - Settle counter <= SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - Counter decrements once per cycle.
  - When the counter is 0: FIL_ACK = 1 for that single cycle, then go to HOLD.
  - With SETTLE_CYCLES = 0, FIL_ACK is asserted in the first cycle after the FAULT_ID update.
  - In general FIL_ACK rises SETTLE_CYCLES+1 clocks after the edge that updated FAULT_ID.
- HOLD: fault held stable. On inc_edge:
  - If INJ_COUNT == ERR_TOTAL: go to DONE, FAULT_VALID <= 0, FIL_END <= 1.
  - Else: FAULT_ID <= FAULT_ID+1, INJ_COUNT <= INJ_COUNT+1, reload the settle counter, go to SETTLE.
- DONE:
  - FIL_END = 1 and sticky until rst.
  - FAULT_VALID = 0; FAULT_ID keeps its last value (ERR_TOTAL-1).
  - Further FIL_INC is ignored.
- FIL_INC edge during SETTLE: ignored, not queued, and does not extend settling. inc_d still tracks FIL_INC, so the level must fall and rise again to be seen.
- ERR_TOTAL = 1: a single fault, ID 0. The second inc_edge (in HOLD) goes to DONE.
- Arithmetic: FAULT_ID never wraps. Reaching ERR_TOTAL is checked before any increment.
- Reset mid-operation, from any state: everything returns to GOLDEN and the list restarts at fault 0.
- Registered outputs: all outputs are registered. FAULT_POL is combinational from the FAULT_ID register.

Optional Feature:
- Macro: FIL_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in HOLD and clears on entry to HOLD and on inc_edge.
  - If it reaches TIMEOUT-1 with no inc_edge, the block behaves exactly as if inc_edge occurred that cycle (advance, or go to DONE) and sets TIMEOUT_FLAG.
  - TIMEOUT_FLAG is sticky until rst.
- When undefined:
  - No watchdog logic; HOLD waits indefinitely.
  - TIMEOUT_FLAG is driven constant 0 and the port remains present.

Test Plan:
- Reset and golden hold: rst for 2 cycles, then FIL_INC = 0 for 50 cycles -> FAULT_VALID = 0, FIL_END = 0, INJ_COUNT = 0, FIL_ACK never high.
- Settle timing (ERR_TOTAL=4, SETTLE_CYCLES=2): FIL_INC edge at clock k -> FAULT_ID = 0 and FAULT_VALID = 1 after k; FIL_ACK high only in the cycle after clock k+3.
- Full list (ERR_TOTAL=4): 5 FIL_INC pulses spaced 10 cycles -> FAULT_ID sequence 0,1,2,3 and FAULT_POL sequence 0,1,0,1; 5th pulse gives FIL_END = 1, FAULT_VALID = 0, INJ_COUNT = 4. A 6th pulse changes nothing.
- Ignored edges: FIL_INC held high 20 cycles -> only one advance. A pulse inside the SETTLE window -> no advance and FAULT_ID unchanged.
- Reset mid-run: rst asserted while FAULT_ID = 2 -> next cycle FAULT_ID = 0, INJ_COUNT = 0, FAULT_VALID = 0, FIL_END = 0. The next FIL_INC restarts at fault 0.
- Watchdog (FIL_TIMEOUT_EN, TIMEOUT=16): no FIL_INC for 16 cycles in HOLD -> FAULT_ID increments and TIMEOUT_FLAG = 1 until rst. Without the macro, the same stimulus -> no advance and TIMEOUT_FLAG = 0.

Source files
------------

// File: rtl/fil_sequencer.sv
// fil_sequencer -- fault-injection-list sequencer.
//
// Responds to the controller's FIL_INC / FIL_END handshake. Each rising edge
// of FIL_INC selects the next fault of the list, holds it for SETTLE_CYCLES
// so the CUT can settle, then pulses FIL_ACK. One request after the last
// fault has been served raises the sticky FIL_END flag.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   FIL_INC      level request from the controller (rising edge acted on)
//   FAULT_ID     index of the currently injected fault
//   FAULT_POL    stuck-at value, equal to FAULT_ID[0] (even SA0, odd SA1)
//   FAULT_VALID  a fault is being injected (0 = golden, fault-free run)
//   FIL_ACK      one-cycle pulse, the current fault has settled
//   FIL_END      sticky, every fault in the list has been served
//   INJ_COUNT    number of faults injected so far
//   TIMEOUT_FLAG sticky watchdog flag (constant 0 without FIL_TIMEOUT_EN)
//
// Optional feature macro: FIL_TIMEOUT_EN
//   When defined, a HOLD-state watchdog advances the list by itself after
//   TIMEOUT cycles without a request and sets TIMEOUT_FLAG.

module fil_sequencer #(
  parameter int TOT_FAULT_BITS = 10,
  parameter int ERR_TOTAL      = 528,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT        = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      FIL_INC,
  output logic [TOT_FAULT_BITS-1:0] FAULT_ID,
  output logic                      FAULT_POL,
  output logic                      FAULT_VALID,
  output logic                      FIL_ACK,
  output logic                      FIL_END,
  output logic [TOT_FAULT_BITS-1:0] INJ_COUNT,
  output logic                      TIMEOUT_FLAG
);

  // Elaboration-time guard on the parameter set.
  if (ERR_TOTAL < 1 || ERR_TOTAL >= 2**TOT_FAULT_BITS ||
      SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255 || TIMEOUT < 1) begin : g_param_check
    $error("fil_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {GOLDEN, SETTLE, HOLD, DONE} state_t;

  state_t     state;
  logic       inc_d;
  logic [7:0] settle_cnt;
  logic       inc_edge;
  logic       advance;

  assign inc_edge  = FIL_INC & ~inc_d;
  assign FAULT_POL = FAULT_ID[0];

`ifdef FIL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;

  // The watchdog stands in for a missing request: it fires on the cycle the
  // count reaches TIMEOUT-1 in HOLD, and only when no real edge is present.
  assign wd_fire = (state == HOLD) && !inc_edge && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign advance = inc_edge | wd_fire;

  // Counter stays at zero outside HOLD, so it is already cleared on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt       <= '0;
      TIMEOUT_FLAG <= 1'b0;
    end else begin
      if (state != HOLD || inc_edge) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_fire) begin
        TIMEOUT_FLAG <= 1'b1;
      end
    end
  end
`else
  assign advance      = inc_edge;
  assign TIMEOUT_FLAG = 1'b0;
`endif

  // Main sequencer. Edges seen in SETTLE or DONE are dropped, not queued;
  // inc_d keeps tracking FIL_INC so a held level is never seen twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GOLDEN;
      inc_d       <= 1'b0;
      settle_cnt  <= '0;
      FAULT_ID    <= '0;
      FAULT_VALID <= 1'b0;
      FIL_ACK     <= 1'b0;
      FIL_END     <= 1'b0;
      INJ_COUNT   <= '0;
    end else begin
      inc_d   <= FIL_INC;
      FIL_ACK <= 1'b0;
      case (state)
        GOLDEN: begin
          if (inc_edge) begin
            FAULT_ID    <= '0;
            FAULT_VALID <= 1'b1;
            INJ_COUNT   <= TOT_FAULT_BITS'(1);
            settle_cnt  <= 8'(SETTLE_CYCLES);
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            FIL_ACK <= 1'b1;
            state   <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        HOLD: begin
          // The end-of-list test comes first so FAULT_ID never wraps.
          if (advance) begin
            if (INJ_COUNT == TOT_FAULT_BITS'(ERR_TOTAL)) begin
              FAULT_VALID <= 1'b0;
              FIL_END     <= 1'b1;
              state       <= DONE;
            end else begin
              FAULT_ID   <= FAULT_ID + 1'b1;
              INJ_COUNT  <= INJ_COUNT + 1'b1;
              settle_cnt <= 8'(SETTLE_CYCLES);
              state      <= SETTLE;
            end
          end
        end
        DONE: begin
          FIL_END <= 1'b1;
        end
        default: begin
          state <= GOLDEN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fil_sequencer.sv
// tb_fil_sequencer -- self-checking bench for fil_sequencer.
//
// A reference model describes the list in terms of "faults served so far"
// and "clock at which the current fault was selected"; the expected outputs
// follow from cycle arithmetic on those two numbers. Scenario tasks drive
// the DUT and compare against the model (and against fixed values where the
// scenario pins them down).

module tb_fil_sequencer;

  localparam int TFB = 10;
  localparam int ERR = 4;
  localparam int SET = 2;
  localparam int TO  = 16;
`ifdef FIL_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           FIL_INC;
  logic [TFB-1:0] FAULT_ID;
  logic           FAULT_POL;
  logic           FAULT_VALID;
  logic           FIL_ACK;
  logic           FIL_END;
  logic [TFB-1:0] INJ_COUNT;
  logic           TIMEOUT_FLAG;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  fil_sequencer #(
    .TOT_FAULT_BITS(TFB),
    .ERR_TOTAL     (ERR),
    .SETTLE_CYCLES (SET),
    .TIMEOUT       (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .FIL_INC     (FIL_INC),
    .FAULT_ID    (FAULT_ID),
    .FAULT_POL   (FAULT_POL),
    .FAULT_VALID (FAULT_VALID),
    .FIL_ACK     (FIL_ACK),
    .FIL_END     (FIL_END),
    .INJ_COUNT   (INJ_COUNT),
    .TIMEOUT_FLAG(TIMEOUT_FLAG)
  );

  always #5 clk = ~clk;

  // {FAULT_ID, FAULT_POL, FAULT_VALID, FIL_ACK, FIL_END, INJ_COUNT, TIMEOUT_FLAG}
  wire logic [24:0] dut_vec = {FAULT_ID, FAULT_POL, FAULT_VALID, FIL_ACK,
                               FIL_END, INJ_COUNT, TIMEOUT_FLAG};

  // cnt: faults served so far; upd: clock index that selected the current
  // fault; last_c: clock index of the most recent update.
  typedef struct packed {
    int cnt;
    bit done;
    int upd;
    bit prev_inc;
    bit tflag;
    int last_c;
  } model_t;

  model_t m;

  // A fault selected at clock u settles through u+SET+1 (ACK clock) and is
  // open to new requests from u+SET+2; the watchdog fires TO clocks after
  // the ACK clock.
  function automatic model_t model_next(model_t cur, bit r, bit inc, int c);
    model_t n = cur;
    bit edge_seen;
    bit timed_out;
    n.last_c = c;
    if (r) begin
      n.cnt      = 0;
      n.done     = 1'b0;
      n.upd      = -1000;
      n.prev_inc = 1'b0;
      n.tflag    = 1'b0;
      return n;
    end
    edge_seen  = inc && !cur.prev_inc;
    n.prev_inc = inc;
    if (cur.done) return n;
    if (cur.cnt == 0) begin
      if (edge_seen) begin
        n.cnt = 1;
        n.upd = c;
      end
      return n;
    end
    if (c >= cur.upd + SET + 2) begin
      timed_out = WD_ON && !edge_seen && (c == cur.upd + SET + 1 + TO);
      if (edge_seen || timed_out) begin
        if (timed_out) n.tflag = 1'b1;
        if (cur.cnt == ERR) begin
          n.done = 1'b1;
        end else begin
          n.cnt = cur.cnt + 1;
          n.upd = c;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [24:0] model_out(model_t cur);
    logic [TFB-1:0] id;
    bit act;
    act = (cur.cnt > 0) && !cur.done;
    id  = (cur.cnt == 0) ? '0 : TFB'(cur.cnt - 1);
    return {id, id[0], act, act && (cur.last_c == cur.upd + SET + 1),
            cur.done, TFB'(cur.cnt), WD_ON && cur.tflag};
  endfunction

  always @(posedge clk) begin
    m   <= model_next(m, rst, FIL_INC, cyc);
    cyc <= cyc + 1;
  end

  // Apply one clock of stimulus and return #1 after the edge.
  task automatic drive(input bit inc, input bit r);
    FIL_INC = inc;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    checks++;
    if ({FAULT_ID, FAULT_POL, FAULT_VALID, FIL_ACK, FIL_END, INJ_COUNT, TIMEOUT_FLAG} !== 25'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h", dut_vec, 25'd0);
    end
    repeat (50) begin
      drive(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_out(m)) begin
        errors++;
        $display("[TB] FAIL golden_idle cyc=%0d: got %h expected %h", cyc, dut_vec, model_out(m));
      end
    end
  endtask

  task automatic test_settle_timing;
    drive(1'b1, 1'b0);
    checks++;
    if ({FAULT_ID, FAULT_VALID, FIL_ACK} !== {10'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL settle_select: got id=%0d valid=%b ack=%b expected id=0 valid=1 ack=0",
               FAULT_ID, FAULT_VALID, FIL_ACK);
    end
    for (int j = 1; j <= 5; j++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (FIL_ACK !== (j == SET + 1)) begin
        errors++;
        $display("[TB] FAIL settle_ack k+%0d: got %b expected %b", j, FIL_ACK, (j == SET + 1));
      end
      checks++;
      if (dut_vec !== model_out(m)) begin
        errors++;
        $display("[TB] FAIL settle_model cyc=%0d: got %h expected %h", cyc, dut_vec, model_out(m));
      end
    end
  endtask

  task automatic test_full_list;
    logic [24:0] exp_v;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      drive(1'b1, 1'b0);
      repeat (9) begin
        drive(1'b0, 1'b0);
        checks++;
        if (dut_vec !== model_out(m)) begin
          errors++;
          $display("[TB] FAIL full_list_model cyc=%0d: got %h expected %h", cyc, dut_vec, model_out(m));
        end
      end
      if (p < ERR) exp_v = {TFB'(p), p[0], 1'b1, 1'b0, 1'b0, TFB'(p + 1), 1'b0};
      else         exp_v = {TFB'(ERR - 1), 1'b1, 1'b0, 1'b0, 1'b1, TFB'(ERR), 1'b0};
      checks++;
      if (dut_vec !== exp_v) begin
        errors++;
        $display("[TB] FAIL full_list pulse=%0d: got %h expected %h", p, dut_vec, exp_v);
      end
    end
  endtask

  task automatic test_ignored_edges;
    int exp_inj;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (8) begin
      drive(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_out(m)) begin
        errors++;
        $display("[TB] FAIL settle_edge_model cyc=%0d: got %h expected %h", cyc, dut_vec, model_out(m));
      end
    end
    checks++;
    if ({FAULT_ID, INJ_COUNT} !== {10'd0, 10'd1}) begin
      errors++;
      $display("[TB] FAIL settle_edge_ignored: got id=%0d inj=%0d expected id=0 inj=1", FAULT_ID, INJ_COUNT);
    end
    repeat (20) begin
      drive(1'b1, 1'b0);
      checks++;
      if (dut_vec !== model_out(m)) begin
        errors++;
        $display("[TB] FAIL held_level_model cyc=%0d: got %h expected %h", cyc, dut_vec, model_out(m));
      end
    end
    drive(1'b0, 1'b0);
    exp_inj = WD_ON ? 3 : 2;
    checks++;
    if (INJ_COUNT !== TFB'(exp_inj)) begin
      errors++;
      $display("[TB] FAIL held_level_once: got inj=%0d expected %0d", INJ_COUNT, exp_inj);
    end
  endtask

  task automatic test_reset_mid_run;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    repeat (3) begin
      drive(1'b1, 1'b0);
      repeat (9) drive(1'b0, 1'b0);
    end
    checks++;
    if (FAULT_ID !== 10'd2) begin
      errors++;
      $display("[TB] FAIL mid_run_setup: got id=%0d expected 2", FAULT_ID);
    end
    drive(1'b0, 1'b1);
    checks++;
    if ({FAULT_ID, INJ_COUNT, FAULT_VALID, FIL_END} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset: got id=%0d inj=%0d valid=%b end=%b expected all 0",
               FAULT_ID, INJ_COUNT, FAULT_VALID, FIL_END);
    end
    drive(1'b1, 1'b0);
    checks++;
    if ({FAULT_ID, INJ_COUNT, FAULT_VALID} !== {10'd0, 10'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mid_run_restart: got id=%0d inj=%0d valid=%b expected 0 1 1",
               FAULT_ID, INJ_COUNT, FAULT_VALID);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_watchdog;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (SET + 1 + TO) begin
      drive(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_out(m)) begin
        errors++;
        $display("[TB] FAIL watchdog_model cyc=%0d: got %h expected %h", cyc, dut_vec, model_out(m));
      end
    end
    checks++;
    if ({FAULT_ID, TIMEOUT_FLAG} !== {TFB'(WD_ON ? 1 : 0), WD_ON}) begin
      errors++;
      $display("[TB] FAIL watchdog_fire: got id=%0d flag=%b expected id=%0d flag=%b",
               FAULT_ID, TIMEOUT_FLAG, WD_ON ? 1 : 0, WD_ON);
    end
    repeat (10) drive(1'b0, 1'b0);
    checks++;
    if (TIMEOUT_FLAG !== WD_ON) begin
      errors++;
      $display("[TB] FAIL watchdog_sticky: got %b expected %b", TIMEOUT_FLAG, WD_ON);
    end
    drive(1'b0, 1'b1);
    checks++;
    if (TIMEOUT_FLAG !== 1'b0) begin
      errors++;
      $display("[TB] FAIL watchdog_reset: got %b expected 0", TIMEOUT_FLAG);
    end
  endtask

  task automatic test_random;
    bit lvl = 1'b0;
    bit r;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) lvl = ~lvl;
      r = ($urandom_range(0, 79) == 0);
      drive(lvl, r);
      checks++;
      if (dut_vec !== model_out(m)) begin
        errors++;
        $display("[TB] FAIL random_model cyc=%0d: got %h expected %h", cyc, dut_vec, model_out(m));
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    FIL_INC = 1'b0;
    $display("[TB] fil_sequencer bench, watchdog build=%0b", WD_ON);
    test_reset();
    test_settle_timing();
    test_full_list();
    test_ignored_edges();
    test_reset_mid_run();
    test_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
